fmul_arbiter: RTL and testbench
===============================

Name: fmul_arbiter

Overview:
- Round-robin arbiter that shares one float_multiplier instance (STB/ACK single-precision A*B => Z) among N_REQ requesters, such as IIR filter stages.
- Serialises one operation at a time: grant, issue operands, collect result, return it to the granted requester, advance the pointer.
- Sits between the filter datapaths and the single multiplier, so the design instantiates one multiplier instead of N_REQ.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant index width; must satisfy 2**ID_W >= N_REQ.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset. Asynchronous, active-high; also routed to the multiplier.
- i_REQ_A  in  32*N_REQ  operand A; requester k occupies bits [32k+31:32k].
- i_REQ_B  in  32*N_REQ  operand B, same packing as i_REQ_A.
- i_REQ_STB  in  N_REQ  requester k holds bit k high until it sees o_REQ_ACK[k].
- o_REQ_ACK  out  N_REQ  one-cycle pulse: operands of requester k captured.
- o_RES_Z  out  32  result; valid while any o_RES_STB bit is high.
- o_RES_STB  out  N_REQ  result valid for requester k; held until acknowledged.
- i_RES_ACK  in  N_REQ  requester k accepts the result.
- o_MUL_A, o_MUL_B  out  32 each  operands to the multiplier.
- o_MUL_AB_STB  out  1  operands valid.
- i_MUL_AB_ACK  in  1  multiplier ready for operands.
- i_MUL_Z  in  32  multiplier result.
- i_MUL_Z_STB  in  1  multiplier result valid.
- o_MUL_Z_ACK  out  1  arbiter accepts the result.
- o_BUSY  out  1  high in every state except IDLE.
- o_GRANT_ID  out  ID_W  index of the current or last grant.

Behaviour:
- All outputs are registers. Reset values: every STB and ACK is 0, o_RES_Z=0, o_MUL_A=0, o_MUL_B=0, o_BUSY=0, o_GRANT_ID=0, round-robin pointer rr=0, state=IDLE.
- A transfer happens on any interface only in a cycle where STB and ACK are both high.
- FSM:
  - IDLE: if i_REQ_STB != 0, choose g = first set bit searching from rr upward, wrapping N_REQ-1 -> 0. Register the operand slices of g into o_MUL_A and o_MUL_B, set o_REQ_ACK[g]=1 and o_GRANT_ID=g, go to ISSUE. If no request, stay.
  - ISSUE: clear o_REQ_ACK and assert o_MUL_AB_STB. When o_MUL_AB_STB and i_MUL_AB_ACK are both high, clear o_MUL_AB_STB and go to WAIT_Z.
  - WAIT_Z: assert o_MUL_Z_ACK. When i_MUL_Z_STB and o_MUL_Z_ACK are both high, register i_MUL_Z into o_RES_Z, clear o_MUL_Z_ACK and go to DELIVER.
  - DELIVER: assert o_RES_STB[g]. When i_RES_ACK[g] is high, clear o_RES_STB, set rr = (g+1) mod N_REQ and go to IDLE.
- Pulse and hold rules:
  - o_REQ_ACK[g] is high for exactly one cycle, the cycle after grant.
  - The requester may change its operands once it has seen the ACK.
- Latency: the arbiter adds 1 cycle grant + 1 cycle issue + 1 cycle capture + 1 cycle deliver around the multiplier's own latency, which is variable because of its normalise loops.
- Back-to-back: a new grant can occur in the IDLE cycle immediately after DELIVER completes.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per operation, chosen by priority from rr. rr advances only on completion, so no requester starves. Worst-case wait is N_REQ-1 operations.
  - Single active requester: it is served repeatedly; rr wraps correctly.
  - A requester dropping STB before ACK is a protocol violation; the arbiter uses only the value sampled in IDLE.
  - i_RES_ACK bits other than bit g are ignored. i_REQ_STB is ignored outside IDLE.
  - The arbiter never asserts o_MUL_AB_STB and o_MUL_Z_ACK together.
  - Special-value results (NaN 0xFFC00000, inf, zero) pass through unmodified.
  - Reset mid-operation: everything returns to its reset value immediately, with no result delivered. The multiplier is reset by the same i_RST.

Decomposition:
- Shared package: FSM state encodings (IDLE=0, ISSUE=1, WAIT_Z=2, DELIVER=3) and FP constants (FP_NAN=0xFFC00000, FP_ONE=0x3F800000) for the benches.
- One natural sub-module: rr_priority_pick. Combinational: inputs request vector and rr; outputs grant index and a valid flag.
- The multiplier is instantiated alongside this block at the level above, not inside it.

Test Plan:
- Single request: requester 0 sends 0x40000000 * 0x40400000 (2.0*3.0) -> o_RES_Z=0x40C00000, o_RES_STB[0] high until acknowledged; o_REQ_ACK[0] pulses exactly 1 cycle.
- Contention, rr=0: requesters 0 and 2 request together -> 0 served first, then 2; rr=3 afterwards. Requester 2 sends 0x3FC00000 * 0xC0000000 (1.5*-2.0) -> 0xC0400000.
- Fairness: all 4 requesters hold STB continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3; every result is routed to the correct STB bit.
- Result backpressure: withhold i_RES_ACK[1] for 20 cycles -> o_RES_STB[1] and o_RES_Z stay stable, no new grant occurs, and o_BUSY stays 1.
- Special value: requester 3 sends 0x7F800000 * 0x00000000 (inf*0) -> 0xFFC00000 delivered to requester 3.
- Reset mid-operation: assert i_RST during WAIT_Z -> all outputs reset asynchronously, rr=0, no result STB. A later request from requester 1 then completes normally.

Source files
------------

// File: rtl/fmul_arbiter_pkg.sv
// Shared definitions for the shared-multiplier arbiter.
// Holds the FSM state encoding, the operand width, and two single-precision
// constants that the benches use as known operands and results.
package fmul_arbiter_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_Z  = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_t;

  localparam logic [FP_W-1:0] FP_NAN = 32'hFFC0_0000;
  localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/fmul_arbiter_rr_pick.sv
// rr_priority_pick: combinational round-robin priority selector.
// Finds the first set bit of i_req, starting at index i_rr and wrapping from
// N_REQ-1 back to 0.
//   i_req  : request vector, one bit per requester
//   i_rr   : index with the highest priority this round
//   o_id   : index of the selected requester (0 when nothing is requested)
//   o_vld  : high when at least one request bit is set
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rr,
  output logic [ID_W-1:0]  o_id,
  output logic             o_vld
);

  int w_idx;

  // Walk the offsets from farthest to nearest so the nearest set bit to i_rr
  // is the last one written and therefore wins.
  always_comb begin
    o_id  = '0;
    o_vld = 1'b0;
    w_idx = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(i_rr) + i) % N_REQ;
      if (i_req[w_idx]) begin
        o_id  = ID_W'(w_idx);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin arbiter that lets N_REQ requesters share one
// STB/ACK single-precision multiplier, one operation at a time.
// Sequence per operation: grant (IDLE) -> issue operands (ISSUE) -> collect
// the product (WAIT_Z) -> hand it to the granted requester (DELIVER).
//   i_CLK, i_RST          : clock, asynchronous active-high reset
//   i_REQ_A/i_REQ_B       : packed operands, requester k at [32k+31:32k]
//   i_REQ_STB/o_REQ_ACK   : operand handshake per requester (ACK = 1-cycle pulse)
//   o_RES_Z               : product returned to the granted requester
//   o_RES_STB/i_RES_ACK   : result handshake per requester
//   o_MUL_A/o_MUL_B       : operands to the multiplier
//   o_MUL_AB_STB/i_MUL_AB_ACK : operand handshake with the multiplier
//   i_MUL_Z, i_MUL_Z_STB/o_MUL_Z_ACK : result handshake with the multiplier
//   o_BUSY                : high whenever the FSM is not in IDLE
//   o_GRANT_ID            : index of the current or most recent grant
module fmul_arbiter
  import fmul_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [FP_W*N_REQ-1:0] i_REQ_A,
  input  logic [FP_W*N_REQ-1:0] i_REQ_B,
  input  logic [N_REQ-1:0]      i_REQ_STB,
  output logic [N_REQ-1:0]      o_REQ_ACK,
  output logic [FP_W-1:0]       o_RES_Z,
  output logic [N_REQ-1:0]      o_RES_STB,
  input  logic [N_REQ-1:0]      i_RES_ACK,
  output logic [FP_W-1:0]       o_MUL_A,
  output logic [FP_W-1:0]       o_MUL_B,
  output logic                  o_MUL_AB_STB,
  input  logic                  i_MUL_AB_ACK,
  input  logic [FP_W-1:0]       i_MUL_Z,
  input  logic                  i_MUL_Z_STB,
  output logic                  o_MUL_Z_ACK,
  output logic                  o_BUSY,
  output logic [ID_W-1:0]       o_GRANT_ID
);

  arb_state_t       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_rr, w_rr_nxt;
  logic [ID_W-1:0]  r_gid, w_gid_nxt;
  logic [N_REQ-1:0] r_req_ack, w_req_ack_nxt;
  logic [N_REQ-1:0] r_res_stb, w_res_stb_nxt;
  logic [FP_W-1:0]  r_mul_a, w_mul_a_nxt;
  logic [FP_W-1:0]  r_mul_b, w_mul_b_nxt;
  logic [FP_W-1:0]  r_res_z, w_res_z_nxt;
  logic             r_ab_stb, w_ab_stb_nxt;
  logic             r_z_ack, w_z_ack_nxt;
  logic             r_busy, w_busy_nxt;

  logic [ID_W-1:0]  w_pick_id;
  logic             w_pick_vld;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_req(i_REQ_STB),
    .i_rr (r_rr),
    .o_id (w_pick_id),
    .o_vld(w_pick_vld)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state   <= ST_IDLE;
      r_rr      <= '0;
      r_gid     <= '0;
      r_req_ack <= '0;
      r_res_stb <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_res_z   <= '0;
      r_ab_stb  <= 1'b0;
      r_z_ack   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr      <= w_rr_nxt;
      r_gid     <= w_gid_nxt;
      r_req_ack <= w_req_ack_nxt;
      r_res_stb <= w_res_stb_nxt;
      r_mul_a   <= w_mul_a_nxt;
      r_mul_b   <= w_mul_b_nxt;
      r_res_z   <= w_res_z_nxt;
      r_ab_stb  <= w_ab_stb_nxt;
      r_z_ack   <= w_z_ack_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_nxt      = r_rr;
    w_gid_nxt     = r_gid;
    // Operand ACK defaults low so it can only ever be a single-cycle pulse.
    w_req_ack_nxt = '0;
    w_res_stb_nxt = r_res_stb;
    w_mul_a_nxt   = r_mul_a;
    w_mul_b_nxt   = r_mul_b;
    w_res_z_nxt   = r_res_z;
    w_ab_stb_nxt  = r_ab_stb;
    w_z_ack_nxt   = r_z_ack;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_mul_a_nxt              = i_REQ_A[32'(w_pick_id)*FP_W +: FP_W];
          w_mul_b_nxt              = i_REQ_B[32'(w_pick_id)*FP_W +: FP_W];
          w_req_ack_nxt[w_pick_id] = 1'b1;
          w_gid_nxt                = w_pick_id;
          w_state_nxt              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_ab_stb && i_MUL_AB_ACK) begin
          w_ab_stb_nxt = 1'b0;
          w_state_nxt  = ST_WAIT_Z;
        end else begin
          w_ab_stb_nxt = 1'b1;
        end
      end
      ST_WAIT_Z: begin
        if (r_z_ack && i_MUL_Z_STB) begin
          w_res_z_nxt = i_MUL_Z;
          w_z_ack_nxt = 1'b0;
          w_state_nxt = ST_DELIVER;
        end else begin
          w_z_ack_nxt = 1'b1;
        end
      end
      ST_DELIVER: begin
        w_res_stb_nxt = '0;
        // Only the granted requester's ACK counts, and only once its STB is out.
        if (r_res_stb[r_gid] && i_RES_ACK[r_gid]) begin
          w_rr_nxt    = (r_gid == ID_W'(N_REQ - 1)) ? '0 : r_gid + ID_W'(1);
          w_state_nxt = ST_IDLE;
        end else begin
          w_res_stb_nxt[r_gid] = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign o_REQ_ACK    = r_req_ack;
  assign o_RES_Z      = r_res_z;
  assign o_RES_STB    = r_res_stb;
  assign o_MUL_A      = r_mul_a;
  assign o_MUL_B      = r_mul_b;
  assign o_MUL_AB_STB = r_ab_stb;
  assign o_MUL_Z_ACK  = r_z_ack;
  assign o_BUSY       = r_busy;
  assign o_GRANT_ID   = r_gid;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: emulates the multiplier and the requesters, keeps a
// transaction-level model (round-robin pointer, one pending operation, expected
// product) and checks grants, routing and results against it.
module tb_fmul_arbiter;
  import fmul_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
  logic [31:0]     res_z, mul_a, mul_b, mul_z;
  logic            mul_ab_stb, mul_ab_ack, mul_z_stb, mul_z_ack, busy;
  logic [IDW-1:0]  gid;

  fmul_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_REQ_A(req_a), .i_REQ_B(req_b), .i_REQ_STB(req_stb), .o_REQ_ACK(req_ack),
    .o_RES_Z(res_z), .o_RES_STB(res_stb), .i_RES_ACK(res_ack),
    .o_MUL_A(mul_a), .o_MUL_B(mul_b), .o_MUL_AB_STB(mul_ab_stb), .i_MUL_AB_ACK(mul_ab_ack),
    .i_MUL_Z(mul_z), .i_MUL_Z_STB(mul_z_stb), .o_MUL_Z_ACK(mul_z_ack),
    .o_BUSY(busy), .o_GRANT_ID(gid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester operand queues and model state
  logic [31:0] qa[N][$];
  logic [31:0] qb[N][$];
  bit          withhold[N];
  int          rr_m;
  bit          m_busy;
  int          m_g;
  logic [31:0] m_z;
  int          grant_log[$];
  int          deliv_cnt[N];
  logic [31:0] last_z[N];
  int          n_deliv;
  bit          mul_stall;
  logic [N-1:0] prev_ack;

  // Products the emulated multiplier knows; x*1.0 = x covers routing tests.
  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_ONE) return b;
    if (b == FP_ONE) return a;
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_C0000000: return 32'hC0400000;
      64'h7F800000_00000000: return FP_NAN;
      default:               return 32'h7FC00001;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = 0; i < N; i++) begin
      if (v[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  // Requester agents, result acceptors and the per-cycle model compare
  initial begin
    int g;
    req_stb = '0; req_a = '0; req_b = '0; res_ack = '0; prev_ack = '0;
    rr_m = 0; m_busy = 0; m_g = 0; m_z = '0; n_deliv = 0;
    for (int k = 0; k < N; k++) begin deliv_cnt[k] = 0; last_z[k] = '0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        rr_m = 0; m_busy = 0; prev_ack = '0; res_ack = '0;
        for (int k = 0; k < N; k++) begin qa[k].delete(); qb[k].delete(); end
      end else begin
        check("ab_stb_zack_exclusive", {63'd0, mul_ab_stb & mul_z_ack}, 64'd0);
        if (prev_ack != 0) check("req_ack_one_cycle", 64'(req_ack), 64'd0);
        if (req_ack != 0) begin
          g = pick(req_stb, rr_m);
          check("grant_while_busy", {63'd0, m_busy}, 64'd0);
          if (g < 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_without_request: ack %0h, stb %0h", req_ack, req_stb);
          end else begin
            check("req_ack_onehot", 64'(req_ack), 64'(1 << g));
            check("grant_id", 64'(gid), 64'(g));
            check("mul_a", 64'(mul_a), 64'(req_a[32*g +: 32]));
            check("mul_b", 64'(mul_b), 64'(req_b[32*g +: 32]));
            m_busy = 1; m_g = g;
            m_z = mul_ref(req_a[32*g +: 32], req_b[32*g +: 32]);
            grant_log.push_back(g);
          end
        end
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        for (int k = 0; k < N; k++) begin
          if (res_ack[k]) begin
            res_ack[k] = 1'b0;
            check("res_stb_drop", 64'(res_stb), 64'd0);
          end
        end
        if (res_stb != 0 && res_ack == 0) begin
          check("res_route", 64'(res_stb), m_busy ? 64'(1 << m_g) : 64'd0);
          if (m_busy && !withhold[m_g]) begin
            check("res_z", 64'(res_z), 64'(m_z));
            res_ack[m_g] = 1'b1;
            deliv_cnt[m_g]++;
            last_z[m_g] = res_z;
            n_deliv++;
            m_busy = 0;
            rr_m = (m_g + 1) % N;
          end
        end
        prev_ack = req_ack;
        for (int k = 0; k < N; k++) begin
          if (req_ack[k] && qa[k].size() > 0) begin
            void'(qa[k].pop_front());
            void'(qb[k].pop_front());
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        req_stb[k]        = (qa[k].size() != 0);
        req_a[32*k +: 32] = (qa[k].size() != 0) ? qa[k][0] : 32'h0;
        req_b[32*k +: 32] = (qb[k].size() != 0) ? qb[k][0] : 32'h0;
      end
    end
  end

  // Emulated multiplier with a deterministic, varying handshake latency
  initial begin
    int m_st, m_cnt, m_ops;
    logic [31:0] m_a, m_b;
    mul_ab_ack = 1'b0; mul_z_stb = 1'b0; mul_z = '0;
    m_st = 0; m_cnt = 0; m_ops = 0; m_a = '0; m_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mul_ab_ack = 1'b0; mul_z_stb = 1'b0; m_st = 0; m_cnt = 0;
      end else begin
        case (m_st)
          0: if (mul_ab_stb) begin
               if (m_cnt > 0) m_cnt--;
               else begin mul_ab_ack = 1'b1; m_a = mul_a; m_b = mul_b; m_st = 1; end
             end
          1: begin mul_ab_ack = 1'b0; m_cnt = 1 + m_ops % 4; m_st = 2; end
          2: if (m_cnt > 1) m_cnt--;
             else if (!mul_stall) begin
               mul_z_stb = 1'b1; mul_z = mul_ref(m_a, m_b);
               m_st = mul_z_ack ? 4 : 3;
             end
          3: if (mul_z_ack) m_st = 4;
          default: begin mul_z_stb = 1'b0; m_ops++; m_cnt = m_ops % 3; m_st = 0; end
        endcase
      end
    end
  end

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
    qa[k].push_back(a);
    qb[k].push_back(b);
  endtask

  task automatic wait_deliv(input string name, input int target, input int budget);
    int c = 0;
    while (n_deliv < target && c < budget) begin @(negedge clk); c++; end
    #1;
    if (n_deliv < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: delivered %0d, required %0d", name, n_deliv, target);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    grant_log.delete();
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    int base, c, cnt2;
    logic [31:0] snap;
    rst = 1'b1; mul_stall = 0;
    for (int k = 0; k < N; k++) withhold[k] = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 64'({busy, gid, res_stb, req_ack, mul_ab_stb, mul_z_ack}), 64'd0);
    check("reset_data", {res_z, mul_a}, 64'd0);
    check("reset_mul_b", 64'(mul_b), 64'd0);
    #1 rst = 1'b0;

    // Single request: 2.0 * 3.0
    push(0, 32'h40000000, 32'h40400000);
    wait_deliv("single", 1, 200);
    check("single_z", 64'(last_z[0]), 64'h40C00000);
    check("single_grant", 64'(grant_log[0]), 64'd0);

    // Contention from rr=0: requesters 0 and 2 together
    pulse_reset();
    base = n_deliv;
    push(0, FP_ONE, 32'h41200000);
    push(2, 32'h3FC00000, 32'hC0000000);
    wait_deliv("contention", base + 2, 300);
    check("cont_first", 64'(grant_log[0]), 64'd0);
    check("cont_second", 64'(grant_log[1]), 64'd2);
    check("cont_z2", 64'(last_z[2]), 64'hC0400000);
    check("cont_rr", 64'(rr_m), 64'd3);

    // Special value: inf * 0 from requester 3
    base = n_deliv;
    push(3, 32'h7F800000, 32'h00000000);
    wait_deliv("special", base + 1, 200);
    check("special_grant", 64'(grant_log[$]), 64'd3);
    check("special_z", 64'(last_z[3]), 64'hFFC00000);

    // Fairness: all four hold STB for two operations each
    grant_log.delete();
    base = n_deliv;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, FP_ONE, 32'h40000000 + 32'(k << 16) + 32'(r));
    wait_deliv("fair", base + 8, 600);
    for (int i = 0; i < 8; i++) check("fair_order", 64'(grant_log[i]), 64'(exp_order[i]));
    for (int k = 0; k < N; k++) check("fair_last_z", 64'(last_z[k]), 64'(32'h40000001 + 32'(k << 16)));

    // Result backpressure on requester 1 with requester 0 waiting
    withhold[1] = 1;
    base = n_deliv;
    push(1, FP_ONE, 32'h3F000000);
    c = 0;
    while (!res_stb[1] && c < 100) begin @(negedge clk); c++; end
    #1;
    check("bp_stb_seen", 64'(res_stb), 64'b0010);
    check("bp_z", 64'(res_z), 64'h3F000000);
    snap = res_z;
    push(0, FP_ONE, 32'h40800000);
    repeat (20) begin
      @(negedge clk); #1;
      check("bp_hold_stb", 64'(res_stb), 64'b0010);
      check("bp_hold_z", 64'(res_z), 64'(snap));
      check("bp_busy", {63'd0, busy}, 64'd1);
      check("bp_no_grant", 64'(req_ack), 64'd0);
    end
    withhold[1] = 0;
    wait_deliv("bp", base + 2, 300);
    check("bp_order_a", 64'(grant_log[$-1]), 64'd1);
    check("bp_order_b", 64'(grant_log[$]), 64'd0);

    // Reset during WAIT_Z: no result for requester 2, pointer back to 0
    mul_stall = 1;
    cnt2 = deliv_cnt[2];
    push(2, 32'h40000000, 32'h40400000);
    c = 0;
    while (!mul_z_ack && c < 100) begin @(negedge clk); c++; end
    check("midrst_wait_z", {63'd0, mul_z_ack}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'({busy, gid, res_stb, req_ack, mul_ab_stb, mul_z_ack}), 64'd0);
    check("midrst_data", {res_z, mul_a}, 64'd0);
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
    mul_stall = 0;
    grant_log.delete();
    base = n_deliv;
    push(0, FP_ONE, 32'h40A00000);
    push(1, FP_ONE, 32'h40490FDB);
    wait_deliv("after_rst", base + 2, 300);
    check("after_rst_no_res2", 64'(deliv_cnt[2]), 64'(cnt2));
    check("after_rst_first", 64'(grant_log[0]), 64'd0);
    check("after_rst_second", 64'(grant_log[1]), 64'd1);
    check("after_rst_z1", 64'(last_z[1]), 64'h40490FDB);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
